// File: rtl/serial_shift32_if.sv
// Request/result bundle for serial_shift32: operand, shift amount and direction in;
// registered result plus BUSY/DONE status out.
interface serial_shift32_if;
  logic        START;
  logic [31:0] D;
  logic [31:0] S;
  logic        LnR;
  logic [31:0] Y;
  logic        BUSY;
  logic        DONE;

  modport master (output START, D, S, LnR, input Y, BUSY, DONE);
  modport slave  (input START, D, S, LnR, output Y, BUSY, DONE);
endinterface

// File: rtl/serial_shift32.sv
// Bit-serial 32-bit logical shifter: moves one bit per cycle, then publishes the
// result in Y with a one-cycle DONE pulse. Shift amounts of 32 or more yield 0.
module serial_shift32 (
  input  logic            CLK,
  input  logic            RST,
  serial_shift32_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FIN = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] w, w_nxt;
  logic [31:0] y, y_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        dir, dir_nxt;
  logic        accept;
  logic        ovf;

  // FIN accepts as well as IDLE so back-to-back requests see no bubble.
  assign accept = bus.START && (state == IDLE || state == FIN);
  assign ovf    = |bus.S[31:5];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      w     <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      w     <= w_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
      y     <= y_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    y_nxt     = y;
    case (state)
      SHIFT: begin
        if (cnt != 5'd0) begin
          w_nxt   = dir ? {w[30:0], 1'b0} : {1'b0, w[31:1]};
          cnt_nxt = cnt - 5'd1;
        end else begin
          y_nxt     = w;
          state_nxt = FIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      // Overflow loads a zero operand with no shifting, so the result is 0.
      w_nxt     = ovf ? 32'd0 : bus.D;
      cnt_nxt   = ovf ? 5'd0 : bus.S[4:0];
      dir_nxt   = bus.LnR;
      state_nxt = SHIFT;
    end
  end

  assign bus.Y    = y;
  assign bus.BUSY = (state == SHIFT);
  assign bus.DONE = (state == FIN);
endmodule

// File: tb/tb_serial_shift32.sv
// Random and directed bench for serial_shift32 against a request-level model
// (result = plain shift operator, completion = accept cycle + n + 1).
module tb_serial_shift32;
  logic CLK;
  logic RST;
  serial_shift32_if bus();

  serial_shift32 dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model state: pending request and its due cycle.
  int          cyc = 0;
  int          n_acc = 0;
  bit          pend = 0;
  int          due = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_y = '0;
  bit          m_done = 0;

  // Literal expectations pushed by directed tests.
  logic [31:0] pin_y [64];
  int          pin_lat [64];
  int          pin_wr = 0;
  int          pin_rd = 0;
  int          tmo_cnt = 0;
  int          tmo_seen = 0;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
    if (!RST) begin
      pend = 0;
      m_y = '0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (pend) begin
        if (cyc == due) begin
          m_y = m_res;
          m_done = 1;
          pend = 0;
        end
      end else if (bus.START) begin
        m_res = bus.LnR ? (bus.D << bus.S) : (bus.D >> bus.S);
        due = cyc + ((bus.S > 32'd31) ? 0 : int'(bus.S)) + 1;
        pend = 1;
        n_acc++;
      end
    end
  end

  initial begin
    bit prev_busy;
    int rise_c;
    prev_busy = 0;
    rise_c = 0;
    forever begin
      @(negedge CLK);
      if (cyc >= 1) begin
        chk("y", bus.Y, m_y);
        chk("busy", {31'd0, bus.BUSY}, {31'd0, pend});
        chk("done", {31'd0, bus.DONE}, {31'd0, m_done});
        if (tmo_cnt != tmo_seen) begin
          tmo_seen = tmo_cnt;
          chk("done_timeout", 32'd1, 32'd0);
        end
        if (bus.BUSY && !prev_busy) rise_c = cyc;
        if (bus.DONE === 1'b1 && pin_rd < pin_wr) begin
          chk("pin_y", bus.Y, pin_y[pin_rd]);
          chk("pin_latency", cyc - rise_c, pin_lat[pin_rd]);
          pin_rd++;
        end
        prev_busy = bus.BUSY;
      end
    end
  end

  task automatic pin(input logic [31:0] ey, input int el);
    pin_y[pin_wr] = ey;
    pin_lat[pin_wr] = el;
    pin_wr++;
  endtask

  task automatic wait_done();
    int k = 0;
    while (bus.DONE !== 1'b1 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    if (bus.DONE !== 1'b1) tmo_cnt++;
  endtask

  task automatic drive(input logic st, input logic [31:0] d, input logic [31:0] s, input logic l);
    @(negedge CLK);
    bus.START = st;
    bus.D = d;
    bus.S = s;
    bus.LnR = l;
  endtask

  task automatic op(input logic [31:0] d, input logic [31:0] s, input logic l,
                    input logic [31:0] ey, input int el);
    pin(ey, el);
    drive(1'b1, d, s, l);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    wait_done();
  endtask

  initial begin
    int r;
    int base;
    int k;
    RST = 1'b0;
    bus.START = 1'b0;
    bus.D = '0;
    bus.S = '0;
    bus.LnR = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    op(32'h0000_0001, 32'd4, 1'b1, 32'h0000_0010, 5);
    op(32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001, 32);
    op(32'hDEAD_BEEF, 32'd0, 1'b1, 32'hDEAD_BEEF, 1);
    op(32'hDEAD_BEEF, 32'd0, 1'b0, 32'hDEAD_BEEF, 1);
    op(32'hFFFF_FFFF, 32'h0000_0020, 1'b1, 32'h0000_0000, 1);
    op(32'hFFFF_FFFF, 32'h8000_0003, 1'b0, 32'h0000_0000, 1);

    // START pulsed mid-shift with a different operand must be ignored.
    pin(32'hD159_E000, 11);
    drive(1'b1, 32'h1234_5678, 32'd10, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge CLK);
    drive(1'b1, 32'hFFFF_FFFF, 32'd3, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    wait_done();

    // START held through FIN: second request starts with no idle cycle.
    pin(32'h0000_000C, 3);
    pin(32'h0F00_0000, 5);
    drive(1'b1, 32'h0000_0003, 32'd2, 1'b1);
    drive(1'b1, 32'hF000_0000, 32'd4, 1'b0);
    wait_done();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    wait_done();

    // Reset three cycles into a 20-bit shift aborts it.
    drive(1'b1, 32'hABCD_1234, 32'd20, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    op(32'h0000_00FF, 32'd4, 1'b0, 32'h0000_000F, 5);

    base = n_acc;
    k = 0;
    while (n_acc < base + 10000 && k < 80000) begin
      @(negedge CLK);
      k++;
      RST = ($urandom_range(2999) != 0);
      bus.START = ($urandom_range(7) != 0);
      bus.D = $urandom;
      bus.LnR = $urandom_range(1);
      r = $urandom_range(99);
      if (r < 30)      bus.S = $urandom | (32'd1 << $urandom_range(31, 5));
      else if (r < 92) bus.S = $urandom_range(7);
      else             bus.S = $urandom_range(31);
    end
    if (n_acc < base + 10000) tmo_cnt++;
    @(negedge CLK);
    RST = 1'b1;
    bus.START = 1'b0;
    repeat (40) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
